yrv_irq_stim: RTL and testbench



---
 rtl/yrv_irq_stim.sv | 159 +++++++++++++++
 tb/tb_yrv_irq_stim.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yrv_irq_stim.sv
// ---------------------------------------------------------------------------
// yrv_irq_stim -- multi-channel periodic interrupt/event stimulus generator
//
// Drives ei_req/nmi_req-style request lines at programmable intervals. Each
// channel has its own interval counter, and each channel runs in either
// pulse mode or level (held-until-acknowledged) mode. A channel sets its
// sticky overrun flag when a new event arrives before the previous request
// has been consumed.
//
// Optional feature macro: YRV_IRQ_STIM_JITTER_EN
//   When this macro is defined, a 16-bit Fibonacci LFSR adds a per-channel
//   random extension of 0..2^JIT_W-1 cycles to each interval. When it is not
//   defined, no LFSR logic exists and every interval is exact.
//
// Ports:
//   clk          clock
//   resetb       asynchronous active-low reset
//   enable       global run enable
//   period       per-channel interval in cycles, [c*CNT_W +: CNT_W], 0 = off
//   pulse_len    per-channel pulse length, [c*PLS_W +: PLS_W], 0 treated as 1
//   level_mode   per channel: 1 = level/ack mode, 0 = pulse mode
//   irq_ack      per-channel acknowledge for level mode
//   overrun_clr  clears all overrun flags
//   irq_req      request lines (registered)
//   overrun      sticky overrun flags (registered)
// ---------------------------------------------------------------------------
module yrv_irq_stim #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16,
  parameter int PLS_W    = 4
`ifdef YRV_IRQ_STIM_JITTER_EN
  ,
  parameter int          JIT_W = 3,
  parameter logic [15:0] SEED  = 16'hACE1
`endif
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      enable,
  input  logic [CHANNELS*CNT_W-1:0] period,
  input  logic [CHANNELS*PLS_W-1:0] pulse_len,
  input  logic [CHANNELS-1:0]       level_mode,
  input  logic [CHANNELS-1:0]       irq_ack,
  input  logic                      overrun_clr,
  output logic [CHANNELS-1:0]       irq_req,
  output logic [CHANNELS-1:0]       overrun
);

  localparam logic [CNT_W:0] ONE_CW1 = (CNT_W+1)'(1);

`ifdef YRV_IRQ_STIM_JITTER_EN
  // Shared LFSR. It advances only while the generator runs.
  logic [15:0] r_lfsr;
  logic        r_en_d;
  logic        w_lfsr_fb;
  logic [31:0] w_lfsr2;

  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  // Doubling the LFSR lets a jitter field that crosses bit 15 wrap around
  // cleanly to bit 0.
  assign w_lfsr2   = {r_lfsr, r_lfsr};

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_lfsr <= SEED;
      r_en_d <= 1'b0;
    end else begin
      r_en_d <= enable;
      if (enable) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_ch
      logic [CNT_W-1:0] w_period;
      logic [PLS_W-1:0] w_plen;
      logic [CNT_W:0]   w_thr;
      logic             w_event;
      logic             w_ovr_new;
      logic [PLS_W-1:0] w_pcnt_nxt;
      logic             w_pend_nxt;
      logic [CNT_W-1:0] w_cnt_nxt;

      logic [CNT_W-1:0] r_cnt;
      logic [PLS_W-1:0] r_pcnt;
      logic             r_pend;
      logic             r_ovr;
      logic             r_irq;

      assign w_period = period[gi*CNT_W +: CNT_W];
      assign w_plen   = (pulse_len[gi*PLS_W +: PLS_W] == '0) ? PLS_W'(1)
                                                             : pulse_len[gi*PLS_W +: PLS_W];

`ifdef YRV_IRQ_STIM_JITTER_EN
      logic [JIT_W-1:0] r_jit;

      // A new jitter value is taken at every wrap and when the generator
      // starts, so each interval gets an independent extension.
      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) r_jit <= '0;
        else if ((enable && !r_en_d) || w_event)
          r_jit <= w_lfsr2[(gi*JIT_W) % 16 +: JIT_W];
      end

      assign w_thr = {1'b0, w_period} - ONE_CW1 + {{(CNT_W+1-JIT_W){1'b0}}, r_jit};
`else
      assign w_thr = {1'b0, w_period} - ONE_CW1;
`endif

      // The >= compare means that lowering the period below the running count
      // fires an event at once and does not let the count wrap around.
      assign w_event = enable && (w_period != '0) && ({1'b0, r_cnt} >= w_thr);

      // Overrun applies only to the mode selected when the event fires. An
      // ack in the same cycle as the event absorbs the older request.
      assign w_ovr_new = w_event && (level_mode[gi] ? (r_pend && !irq_ack[gi])
                                                    : (r_pcnt != '0));

      always_comb begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (!enable || (w_period == '0) || w_event) w_cnt_nxt = '0;

        // Pulse state and pending state each drain by their own rule, so a
        // mode switch leaves any request that is already active unchanged.
        w_pcnt_nxt = r_pcnt;
        if (!enable)                         w_pcnt_nxt = '0;
        else if (w_event && !level_mode[gi]) w_pcnt_nxt = w_plen;
        else if (r_pcnt != '0)               w_pcnt_nxt = r_pcnt - PLS_W'(1);

        w_pend_nxt = r_pend;
        if (w_event && level_mode[gi]) w_pend_nxt = 1'b1;
        else if (irq_ack[gi])          w_pend_nxt = 1'b0;
      end

      always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
          r_cnt  <= '0;
          r_pcnt <= '0;
          r_pend <= 1'b0;
          r_ovr  <= 1'b0;
          r_irq  <= 1'b0;
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_pcnt <= w_pcnt_nxt;
          r_pend <= w_pend_nxt;
          r_ovr  <= (r_ovr && !overrun_clr) || w_ovr_new;
          r_irq  <= (w_pcnt_nxt != '0) || w_pend_nxt;
        end
      end

      assign irq_req[gi] = r_irq;
      assign overrun[gi] = r_ovr;
    end
  endgenerate

endmodule

// File: tb/tb_yrv_irq_stim.sv
// ---------------------------------------------------------------------------
// Testbench for yrv_irq_stim in its default configuration (no jitter).
// A timestamp-based reference model predicts irq_req and overrun on every
// cycle. Directed scenarios add literal expectations on top of that.
// ---------------------------------------------------------------------------
module tb_yrv_irq_stim;
  localparam int CH = 2;
  localparam int CW = 16;
  localparam int PW = 4;

  logic              clk = 1'b0;
  logic              resetb = 1'b0;
  logic              enable = 1'b0;
  logic [CH*CW-1:0]  period = '0;
  logic [CH*PW-1:0]  pulse_len = '0;
  logic [CH-1:0]     level_mode = '0;
  logic [CH-1:0]     irq_ack = '0;
  logic              overrun_clr = 1'b0;
  logic [CH-1:0]     irq_req;
  logic [CH-1:0]     overrun;

  always #5 clk = ~clk;

  yrv_irq_stim #(.CHANNELS(CH), .CNT_W(CW), .PLS_W(PW)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .period(period),
    .pulse_len(pulse_len), .level_mode(level_mode), .irq_ack(irq_ack),
    .overrun_clr(overrun_clr), .irq_req(irq_req), .overrun(overrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model (timestamps, not counters) ------------
  // cyc numbers the clock edges. start[c] is the edge at which the current
  // interval began, so the cycle that ends at edge n is the (n-start)-th
  // cycle of that interval. pulse_until[c] is the last edge after which the
  // pulse is still high.
  int          cyc = 0;
  int          start[CH];
  int          pulse_until[CH];
  bit          pend[CH];
  bit          m_ovr[CH];
  logic [CH-1:0] exp_irq = '0;
  logic [CH-1:0] exp_ovr = '0;

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int c = 0; c < CH; c++) begin
        start[c] = cyc; pulse_until[c] = cyc - 1; pend[c] = 0; m_ovr[c] = 0;
      end
      exp_irq = '0; exp_ovr = '0;
    end else begin
      cyc++;
      for (int c = 0; c < CH; c++) begin
        int  per, len;
        bit  ev, pulse_act, novr;
        per = int'(period[c*CW +: CW]);
        len = int'(pulse_len[c*PW +: PW]);
        if (len == 0) len = 1;
        ev        = enable && (per != 0) && ((cyc - start[c]) >= per);
        pulse_act = (pulse_until[c] >= cyc - 1);
        novr      = 0;
        if (!enable) begin
          start[c] = cyc;
          pulse_until[c] = cyc - 1;
        end else if (per == 0 || ev) begin
          start[c] = cyc;
        end
        if (ev && !level_mode[c]) begin
          if (pulse_act) novr = 1;
          pulse_until[c] = cyc + len - 1;
        end
        if (ev && level_mode[c]) begin
          if (pend[c] && !irq_ack[c]) novr = 1;
          pend[c] = 1;
        end else if (irq_ack[c]) begin
          pend[c] = 0;
        end
        m_ovr[c]   = (m_ovr[c] && !overrun_clr) || novr;
        exp_irq[c] = pend[c] || (pulse_until[c] >= cyc);
        exp_ovr[c] = m_ovr[c];
      end
    end
  end

  // ---------------- per-cycle compare --------------------------------------
  always @(negedge clk) begin
    if (resetb) begin
      check("model_irq_req", 32'(irq_req), 32'(exp_irq));
      check("model_overrun", 32'(overrun), 32'(exp_ovr));
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic run(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic restart();
    resetb = 1'b0; enable = 1'b0; period = '0; pulse_len = '0;
    level_mode = '0; irq_ack = '0; overrun_clr = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
  endtask

  initial begin
    int c0, c1, f0, f1, lows;
    logic [CH-1:0] prev;
    run(2);

    // Mid-run asynchronous reset, then a clean 10-cycle first interval.
    restart();
    period = {16'd5, 16'd100}; level_mode = 2'b10; enable = 1'b1;
    run(57);
    check("pre_rst_ovr1", 32'(overrun[1]), 32'd1);
    #3 resetb = 1'b0;
    #1;
    check("async_rst_irq", 32'(irq_req), 32'd0);
    check("async_rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    period = {16'd0, 16'd10}; level_mode = 2'b00; enable = 1'b1; resetb = 1'b1;
    run(9);  check("rst_p10_c9",  32'(irq_req[0]), 32'd0);
    run(1);  check("rst_p10_c10", 32'(irq_req[0]), 32'd1);
    run(1);  check("rst_p10_c11", 32'(irq_req[0]), 32'd0);

    // Two pulse channels over 1000 cycles.
    restart();
    period = {16'd333, 16'd100}; pulse_len = {4'd1, 4'd1}; enable = 1'b1;
    c0 = 0; c1 = 0; f0 = 0; f1 = 0; prev = '0;
    for (int k = 1; k <= 1000; k++) begin
      run(1);
      if (irq_req[0] && !prev[0]) begin c0++; if (f0 == 0) f0 = k; end
      if (irq_req[1] && !prev[1]) begin c1++; if (f1 == 0) f1 = k; end
      prev = irq_req;
    end
    check("ch0_pulse_count", 32'(c0), 32'd10);
    check("ch1_pulse_count", 32'(c1), 32'd3);
    check("ch0_first",       32'(f0), 32'd100);
    check("ch1_first",       32'(f1), 32'd333);
    check("count_no_ovr",    32'(overrun), 32'd0);

    // Level mode without an ack, then a late ack and overrun_clr.
    restart();
    period = {16'd0, 16'd20}; level_mode = 2'b01; enable = 1'b1;
    run(19); check("lvl_c19_irq", 32'(irq_req[0]), 32'd0);
    run(1);  check("lvl_c20_irq", 32'(irq_req[0]), 32'd1);
    run(19); check("lvl_c39_ovr", 32'(overrun[0]), 32'd0);
    run(1);  check("lvl_c40_ovr", 32'(overrun[0]), 32'd1);
    run(5);  irq_ack = 2'b01;
    run(1);  check("lvl_ack_c46", 32'(irq_req[0]), 32'd0);
    irq_ack = 2'b00; overrun_clr = 1'b1;
    run(1);  check("lvl_ovr_clr", 32'(overrun[0]), 32'd0);
    overrun_clr = 1'b0;

    // An ack in the same cycle as an event: the event wins.
    restart();
    period = {16'd0, 16'd8}; level_mode = 2'b01; enable = 1'b1;
    run(8);  check("ackev_c8_irq", 32'(irq_req[0]), 32'd1);
    run(7);  irq_ack = 2'b01;
    run(1);  check("ackev_c16_irq", 32'(irq_req[0]), 32'd1);
             check("ackev_c16_ovr", 32'(overrun[0]), 32'd0);
    irq_ack = 2'b00;

    // A pulse longer than the period, then pulse_len=0.
    restart();
    period = {16'd0, 16'd5}; pulse_len = {4'd0, 4'd7}; enable = 1'b1;
    run(4);  check("long_c4_irq", 32'(irq_req[0]), 32'd0);
    lows = 0;
    for (int k = 5; k <= 40; k++) begin
      run(1);
      if (!irq_req[0]) lows++;
    end
    check("long_never_drops", 32'(lows), 32'd0);
    check("long_ovr", 32'(overrun[0]), 32'd1);
    restart();
    period = {16'd0, 16'd5}; pulse_len = '0; enable = 1'b1;
    run(5);  check("len0_c5",  32'(irq_req[0]), 32'd1);
    run(1);  check("len0_c6",  32'(irq_req[0]), 32'd0);
    run(3);  check("len0_c9",  32'(irq_req[0]), 32'd0);
    run(1);  check("len0_c10", 32'(irq_req[0]), 32'd1);
    check("len0_no_ovr", 32'(overrun[0]), 32'd0);

    // Period decrease below the running count.
    restart();
    period = {16'd0, 16'd100}; pulse_len = {4'd0, 4'd1}; enable = 1'b1;
    run(50); period = {16'd0, 16'd30};
    run(1);  check("pchg_c51", 32'(irq_req[0]), 32'd1);
    run(29); check("pchg_c80", 32'(irq_req[0]), 32'd0);
    run(1);  check("pchg_c81", 32'(irq_req[0]), 32'd1);

    // Disable for 3 cycles: pulse cut, level pending retained, full restart.
    restart();
    period = {16'd10, 16'd10}; pulse_len = {4'd0, 4'd15}; level_mode = 2'b10;
    enable = 1'b1;
    run(12); check("en_c12_irq", 32'(irq_req), 32'd3);
    enable = 1'b0;
    run(1);  check("en_off_c13", 32'(irq_req), 32'd2);
    run(2);  check("en_off_c15", 32'(irq_req), 32'd2);
    enable = 1'b1;
    run(9);  check("en_re_c24", 32'(irq_req[0]), 32'd0);
    run(1);  check("en_re_c25", 32'(irq_req), 32'd3);
             check("en_re_ovr", 32'(overrun), 32'd2);

    // Randomised blocks checked by the per-cycle model.
    restart();
    for (int blk = 0; blk < 40; blk++) begin
      for (int c = 0; c < CH; c++) begin
        period[c*CW +: CW]    = ($urandom_range(0, 7) == 0) ? 16'd0
                                                            : 16'($urandom_range(1, 12));
        pulse_len[c*PW +: PW] = 4'($urandom_range(0, 15));
      end
      level_mode = 2'($urandom_range(0, 3));
      if (blk == 20) begin
        #3 resetb = 1'b0;
        #1;
        check("rand_rst_irq", 32'(irq_req), 32'd0);
        check("rand_rst_ovr", 32'(overrun), 32'd0);
        @(negedge clk);
        resetb = 1'b1;
      end
      for (int k = 0; k < 60; k++) begin
        enable      = ($urandom_range(0, 19) != 0);
        irq_ack     = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
        overrun_clr = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 29) == 0)
          period[0 +: CW] = 16'($urandom_range(0, 12));
        run(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
